// File: rtl/fns_ftf_encoder_pipe.sv
// Pipelined Fibonacci-numeral-system forbidden-transition-free encoder.
// One codeword bit is decided per stage, MSB first, with a global-stall valid/ready stream.
module fns_ftf_encoder_pipe #(
  parameter int CW = 6,
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_code,
  output logic          out_err
);

  function automatic int unsigned fib(input int n);
    int unsigned a;
    int unsigned b;
    int unsigned t;
    a = 1;
    b = 1;
    for (int i = 3; i <= n; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return b;
  endfunction

  localparam int unsigned   RANGE   = fib(CW + 2);
  localparam int            RW      = (DW > $clog2(RANGE)) ? DW : $clog2(RANGE);
  localparam logic [31:0]   RANGE_W = 32'(RANGE);
  localparam logic [RW-1:0] SAT     = RW'(RANGE - 1);

  logic          adv;
  logic          err_in;
  logic          valid_reg [CW];
  logic          err_reg   [CW];
  logic [RW-1:0] res_reg   [CW];
  logic [CW-1:0] code_reg  [CW];
  logic [RW-1:0] res_next  [CW];
  logic [CW-1:0] code_next [CW];

  assign out_valid = valid_reg[CW-1];
  assign out_code  = code_reg[CW-1];
  assign out_err   = err_reg[CW-1];

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv || !rst_n;

  // Out-of-range inputs saturate to the largest codable value.
  assign err_in       = {{(32-DW){1'b0}}, in_data} >= RANGE_W;
  assign res_next[0]  = err_in ? SAT : RW'(in_data);
  assign code_next[0] = '0;

  for (genvar gi = 1; gi < CW; gi++) begin : g_stage
    localparam int            K    = CW - gi + 1;
    localparam logic [RW-1:0] F_LO = RW'(fib(K));
    localparam logic [RW-1:0] F_HI = RW'(fib(K + 1));

    logic          prev_bit;
    logic          bit_d;
    logic [RW-1:0] res_in;
    logic [RW-1:0] res_out;

    // The MSB stage behaves like any other with an implicit d[CW+1]=0.
    if (gi == 1) begin : g_top
      assign prev_bit = 1'b0;
    end else begin : g_mid
      assign prev_bit = code_reg[gi-1][K];
    end

    assign res_in       = res_reg[gi-1];
    assign bit_d        = (res_in >= F_HI) || ((res_in >= F_LO) && prev_bit);
    assign res_out      = bit_d ? res_in - F_LO : res_in;
    assign res_next[gi] = res_out;

    if (gi == CW - 1) begin : g_last
      assign code_next[gi] = code_reg[gi-1] | (CW'(bit_d) << (K - 1)) | CW'(res_out[0]);
    end else begin : g_body
      assign code_next[gi] = code_reg[gi-1] | (CW'(bit_d) << (K - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < CW; i++) begin
        valid_reg[i] <= 1'b0;
        err_reg[i]   <= 1'b0;
        res_reg[i]   <= '0;
        code_reg[i]  <= '0;
      end
    end else if (adv) begin
      valid_reg[0] <= in_valid;
      err_reg[0]   <= err_in;
      res_reg[0]   <= res_next[0];
      code_reg[0]  <= code_next[0];
      for (int i = 1; i < CW; i++) begin
        valid_reg[i] <= valid_reg[i-1];
        err_reg[i]   <= err_reg[i-1];
        res_reg[i]   <= res_next[i];
        code_reg[i]  <= code_next[i];
      end
    end
  end

endmodule

// File: tb/tb_fns_ftf_encoder_pipe.sv
// Scoreboard bench for fns_ftf_encoder_pipe over three configurations run side by side:
// (CW=6,DW=4) directed/sweep/backpressure/reset, (6,5) range handling, (8,5) random flow control.
module tb_fns_ftf_encoder_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          v;
    logic [15:0] code;
    logic        err;
    int          acc_edge;
    bit          lat;
  } exp_t;

  function automatic int fibn(input int n);
    int a = 1;
    int b = 1;
    int t;
    for (int i = 3; i <= n; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return b;
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_cfg
    localparam int CWS = (gi == 2) ? 8 : 6;
    localparam int DWS = (gi == 0) ? 4 : 5;

    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [DWS-1:0] in_data;
    logic           out_valid;
    logic           out_ready;
    logic [CWS-1:0] out_code;
    logic           out_err;

    int   cyc = 0;
    bit   fin = 1'b0;
    bit   stop_rdy = 1'b0;
    exp_t q[$];

    fns_ftf_encoder_pipe #(.CW(CWS), .DW(DWS)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_code  (out_code),
      .out_err   (out_err)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string what, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
        bad++;
        $display("FAIL cfg%0d %s: got %0h want %0h", gi, what, act, req);
      end
    endtask

    // Greedy rule: take a weight when forced, skip it when impossible, otherwise copy the bit above.
    function automatic exp_t model(input int v);
      exp_t e;
      int   rng = fibn(CWS + 2);
      int   r;
      bit   prev = 1'b0;
      bit   d;
      e.v = v;
      e.code = '0;
      e.err = (v >= rng);
      e.acc_edge = 0;
      e.lat = 1'b0;
      r = e.err ? rng - 1 : v;
      for (int k = CWS; k >= 2; k--) begin
        if (r >= fibn(k + 1)) d = 1'b1;
        else if (r < fibn(k)) d = 1'b0;
        else d = prev;
        if (d) r -= fibn(k);
        e.code[k-1] = d;
        prev = d;
      end
      e.code[0] = (r == 1);
      return e;
    endfunction

    function automatic int wsum(input logic [CWS-1:0] c);
      int s = 0;
      for (int k = 1; k <= CWS; k++) if (c[k-1]) s += fibn(k);
      return s;
    endfunction

    // Called just after a falling edge; returns just after a falling edge.
    task automatic send(input int v, input bit lat, input int tab_code, input bit tab_err);
      exp_t e;
      bit   acc;
      int   waits = 0;
      in_data  = DWS'(v);
      in_valid = 1'b1;
      forever begin
        #2;
        acc = in_ready;
        if (acc) begin
          e = model(v);
          if (tab_code >= 0) begin
            e.code = 16'(tab_code);
            e.err  = tab_err;
          end
          e.acc_edge = cyc + 1;
          e.lat = lat;
          q.push_back(e);
        end
        @(negedge clk);
        if (acc) break;
        waits++;
        if (waits > 200) begin
          total++;
          bad++;
          $display("FAIL cfg%0d accept_timeout: in_ready=0 for %0d cycles want 1", gi, waits);
          break;
        end
      end
      in_valid = 1'b0;
    endtask

    task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 1000) begin
        @(negedge clk);
        n++;
      end
      check("drain_left", 32'(q.size()), 32'd0);
      repeat (2) @(negedge clk);
    endtask

    task automatic init_reset();
      rst_n = 1'b0;
      in_valid = 1'b0;
      in_data = '0;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      #2;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_code", 32'(out_code), 32'd0);
      check("rst_out_err", 32'(out_err), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #2;
      check("post_rst_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
    endtask

    // Monitor: pops on every output handshake and checks held data while stalled.
    initial begin : mon
      exp_t           e;
      bit             stall_prev = 1'b0;
      logic [CWS-1:0] code_prev = '0;
      logic           err_prev = 1'b0;
      int             clamp;
      forever begin
        @(negedge clk);
        #2;
        if (rst_n !== 1'b1) begin
          stall_prev = 1'b0;
        end else begin
          if (stall_prev)
            check("hold", 32'({out_valid, out_err, out_code}), 32'({1'b1, err_prev, code_prev}));
          if (out_valid && out_ready) begin
            if (q.size() == 0) begin
              total++;
              bad++;
              $display("FAIL cfg%0d unexpected_output: got code=%b want no output", gi, out_code);
            end else begin
              e = q.pop_front();
              $display("cfg%0d cyc=%0d in=%0d code=%b err=%0b", gi, cyc, e.v, out_code, out_err);
              check("code_err", 32'({out_err, out_code}), 32'({e.err, e.code[CWS-1:0]}));
              clamp = (e.v >= fibn(CWS + 2)) ? fibn(CWS + 2) - 1 : e.v;
              check("weight_sum", 32'(wsum(out_code)), 32'(clamp));
              if (e.lat) check("latency", 32'(cyc - e.acc_edge), 32'(CWS - 1));
            end
          end
          stall_prev = out_valid && !out_ready;
          code_prev = out_code;
          err_prev = out_err;
        end
      end
    end

    if (gi == 0) begin : g_stim
      int          vals [5] = '{0, 7, 12, 13, 15};
      logic [15:0] codes [5] = '{16'b000000, 16'b001111, 16'b011111, 16'b110000, 16'b110011};
      initial begin
        init_reset();
        for (int i = 0; i < 5; i++) send(vals[i], 1'b1, int'(codes[i]), 1'b0);
        drain();
        for (int v = 0; v < 16; v++) send(v, 1'b1, -1, 1'b0);
        drain();
        // Eight words offered while the consumer stalls for seven cycles.
        fork
          begin
            for (int i = 0; i < 8; i++) send(int'($urandom_range(0, 15)), 1'b0, -1, 1'b0);
          end
          begin
            out_ready = 1'b0;
            repeat (6) @(negedge clk);
            #2;
            check("bp_in_ready_full", 32'(in_ready), 32'd0);
            @(negedge clk);
            out_ready = 1'b1;
          end
        join
        drain();
        for (int i = 0; i < 3; i++) send(int'($urandom_range(0, 15)), 1'b0, -1, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        repeat (8) @(negedge clk);
        send(9, 1'b1, -1, 1'b0);
        drain();
        fin = 1'b1;
      end
    end else if (gi == 1) begin : g_stim
      initial begin
        init_reset();
        send(21, 1'b1, 6'b111111, 1'b1);
        send(31, 1'b1, 6'b111111, 1'b1);
        send(20, 1'b1, 6'b111111, 1'b0);
        for (int v = 0; v < 32; v++) send(v, 1'b1, -1, 1'b0);
        drain();
        fin = 1'b1;
      end
    end else begin : g_stim
      initial begin
        init_reset();
        fork
          begin
            for (int i = 0; i < 10000; i++) begin
              if ($urandom_range(0, 3) == 0) @(negedge clk);
              send(int'($urandom_range(0, 31)), 1'b0, -1, 1'b0);
            end
            stop_rdy = 1'b1;
          end
          begin
            while (!stop_rdy) begin
              out_ready = ($urandom_range(0, 3) != 0);
              @(negedge clk);
            end
            out_ready = 1'b1;
          end
        join
        drain();
        fin = 1'b1;
      end
    end
  end

  initial begin
    for (int i = 0; i < 90000; i++) begin
      if (g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin) break;
      @(negedge clk);
    end
    if (!(g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin)) begin
      total++;
      bad++;
      $display("FAIL timeout: finished=%b%b%b want 111", g_cfg[2].fin, g_cfg[1].fin, g_cfg[0].fin);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
